// File: rtl/top_rca.sv
// Registered ripple-carry adder: {cout,s} <= a + b + cin one clock after an in_valid cycle.
// The carry chain is combinational from the ports straight into the output register.
module top_rca #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum;
    logic             carry;

    logic [WIDTH-1:0] s_d,    s_q;
    logic             cout_d, cout_q;
    logic             out_valid_d, out_valid_q;

    // One loop iteration per full-adder cell; carry ripples from bit 0 upward.
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

    // No backpressure: a result is captured on every in_valid edge, and
    // s/cout hold their last result while in_valid is low.
    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d    = sum;
            cout_d = carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_top_rca.sv
// Scoreboard bench for top_rca: the driver pushes {cout,s} expectations, a monitor
// pops one per out_valid cycle and checks that s/cout hold when out_valid is low.
module tb_top_rca;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic         out_valid;

    logic [W:0]   exp_q[$];
    logic [W:0]   last_exp = '0;
    int           n_cmp = 0;
    int           n_fail = 0;

    top_rca #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one vector for one clock; expected value is pushed at the sampling edge.
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic tv, input logic [W:0] texp);
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = tv;
        @(posedge clk);
        if (tv) exp_q.push_back(texp);
    endtask

    // A reset discards everything in flight and clears the held result.
    always @(posedge rst) begin
        exp_q.delete();
        last_exp = '0;
    end

    initial begin : monitor
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", {1'b0, out_valid, {(W-1){1'b0}}}, '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {cout, s}, e);
                        last_exp = e;
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("missing_out_valid", {1'b0, out_valid, {(W-1){1'b0}}},
                              {1'b0, 1'b1, {(W-1){1'b0}}});
                    end
                    check("hold", {cout, s}, last_exp);
                end
            end
        end
    end

    initial begin : timeout
        #500000;
        $display("FAIL timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0] ra, rb;
        logic         rc, rv;

        // Asynchronous reset with no clock edge in between.
        #1 rst = 1'b1;
        #1;
        check("reset_s", {1'b0, s}, '0);
        check("reset_cout", {{W{1'b0}}, cout}, '0);
        check("reset_out_valid", {{W{1'b0}}, out_valid}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Valid gating around the first result.
        drive(8'h20, 8'h05, 1'b0, 1'b1, 9'h025);
        drive(8'h10, 8'h01, 1'b0, 1'b0, 9'h000);
        @(negedge clk);
        #1;
        check("gate_s_holds", {1'b0, s}, 9'h025);
        check("gate_out_valid_low", {{W{1'b0}}, out_valid}, '0);
        drive(8'h10, 8'h01, 1'b0, 1'b1, 9'h011);

        // Directed vectors, back to back.
        drive(8'h41, 8'h16, 1'b1, 1'b1, 9'h058);
        drive(8'h09, 8'h86, 1'b0, 1'b1, 9'h08F);
        drive(8'h23, 8'h09, 1'b0, 1'b1, 9'h02C);
        drive(8'h03, 8'h47, 1'b1, 1'b1, 9'h04B);
        drive(8'h48, 8'h48, 1'b0, 1'b1, 9'h090);
        drive(8'h8F, 8'h2F, 1'b0, 1'b1, 9'h0BE);
        drive(8'h05, 8'h0A, 1'b0, 1'b1, 9'h00F);

        // Carry ripple, wrap and maximum.
        drive(8'hFF, 8'h00, 1'b1, 1'b1, 9'h100);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF);
        drive(8'h80, 8'h80, 1'b0, 1'b1, 9'h100);
        drive(8'h00, 8'h00, 1'b1, 1'b1, 9'h001);
        drive(8'h01, 8'h7F, 1'b0, 1'b1, 9'h080);
        drive(8'h55, 8'hAA, 1'b1, 1'b1, 9'h100);

        // Random operands with occasional idle cycles.
        for (int i = 0; i < 3000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 4) != 0);
            drive(ra, rb, rc, rv, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
        end

        // Asynchronous reset while holding a non-zero result.
        drive(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_reset_s", {1'b0, s}, '0);
        check("async_reset_cout", {{W{1'b0}}, cout}, '0);
        check("async_reset_out_valid", {{W{1'b0}}, out_valid}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Reset pulse straddling the edge that samples a valid vector.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset_s", {1'b0, s}, '0);
        check("midreset_cout", {{W{1'b0}}, cout}, '0);
        check("midreset_out_valid", {{W{1'b0}}, out_valid}, '0);
        drive(8'h03, 8'h04, 1'b0, 1'b1, 9'h007);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
        @(negedge clk);
        #1;
        check("queue_drained", 9'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
